matrix_mem_ctrl: RTL and testbench

Sequencing controller directly upstream and downstream of the matrix ULA. It accepts one matrix command at a time, reads two 5x5 int8 matrices (25 bytes each) from a byte-wide synchronous memory, and packs them into the 200-bit `matrizA`/`matrizB` operands. It then drives the ULA `start`/`done` handshake, writes the 200-bit result back to memory byte by byte, and signals completion.

---
 rtl/matrix_mem_ctrl_if.sv | 49 ++++
 rtl/matrix_mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_matrix_mem_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mem_ctrl_if.sv
// ============================================================================
//  Module   : matrix_mem_ctrl_if
//  Brief    : Command, byte-memory and ULA handshake bundle of matrix_mem_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface matrix_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [7:0]        cmd_escalar;
    logic [ADDR_W-1:0] cmd_addr_a;
    logic [ADDR_W-1:0] cmd_addr_b;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [3:0]        opcode;
    logic [7:0]        data_escalar;
    logic [199:0]      matrizA;
    logic [199:0]      matrizB;
    logic              start;
    logic [199:0]      matriz_resultante;
    logic              done;
    logic              op_done;

    // Controller side
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_escalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
        input  mem_rdata, matriz_resultante, done,
        output cmd_ready, mem_addr, mem_rd_en, mem_we, mem_wdata,
        output opcode, data_escalar, matrizA, matrizB, start, op_done
    );

    // Environment side: command source, memory and ULA
    modport master (
        output cmd_valid, cmd_opcode, cmd_escalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
        output mem_rdata, matriz_resultante, done,
        input  cmd_ready, mem_addr, mem_rd_en, mem_we, mem_wdata,
        input  opcode, data_escalar, matrizA, matrizB, start, op_done
    );
endinterface

`default_nettype wire

// File: rtl/matrix_mem_ctrl.sv
// ============================================================================
//  Module   : matrix_mem_ctrl
//  Brief    : Loads two 5x5 int8 matrices from byte memory, runs the ULA and
//             stores the 200-bit result back byte by byte.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    matrix_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CAP    = 3'd3,
        S_EXEC   = 3'd4,
        S_STORE  = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    localparam logic [4:0] C_LAST = 5'd24;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_cnt;
    logic [4:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_r;
    logic [3:0]        r_opcode;
    logic [7:0]        r_escalar;
    logic [199:0]      r_mat_a;
    logic [199:0]      r_mat_b;
    logic [199:0]      r_result;
    logic [7:0]        w_prev_lsb;
    logic [7:0]        w_cur_lsb;
    logic [ADDR_W-1:0] w_cnt_ext;

    // Read data lags the read address by one cycle, so captures land on byte k-1
    assign w_prev_lsb = {r_cnt - 5'd1, 3'b000};
    assign w_cur_lsb  = {r_cnt, 3'b000};
    assign w_cnt_ext  = ADDR_W'(r_cnt);

    assign bus.opcode       = r_opcode;
    assign bus.data_escalar = r_escalar;
    assign bus.matrizA      = r_mat_a;
    assign bus.matrizB      = r_mat_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_addr_r  <= '0;
            r_opcode  <= 4'd0;
            r_escalar <= 8'd0;
            r_mat_a   <= '0;
            r_mat_b   <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr_a  <= bus.cmd_addr_a;
                        r_addr_b  <= bus.cmd_addr_b;
                        r_addr_r  <= bus.cmd_addr_r;
                        r_opcode  <= bus.cmd_opcode;
                        r_escalar <= bus.cmd_escalar;
                    end
                end
                S_LOAD_A: begin
                    if (r_cnt != 5'd0)
                        r_mat_a[w_prev_lsb +: 8] <= bus.mem_rdata;
                end
                S_LOAD_B: begin
                    if (r_cnt == 5'd0)
                        r_mat_a[199:192] <= bus.mem_rdata;
                    else
                        r_mat_b[w_prev_lsb +: 8] <= bus.mem_rdata;
                end
                S_CAP: r_mat_b[199:192] <= bus.mem_rdata;
                S_EXEC: begin
                    if (bus.done)
                        r_result <= bus.matriz_resultante;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        bus.cmd_ready = 1'b0;
        bus.mem_rd_en = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'd0;
        bus.start     = 1'b0;
        bus.op_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_nxt = S_LOAD_A;
                    w_cnt_nxt   = 5'd0;
                end
            end
            S_LOAD_A: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = r_addr_a + w_cnt_ext;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_LOAD_B;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
            end
            S_LOAD_B: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = r_addr_b + w_cnt_ext;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_CAP;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
            end
            S_CAP: w_state_nxt = S_EXEC;
            S_EXEC: begin
                bus.start = 1'b1;
                if (bus.done) begin
                    w_state_nxt = S_STORE;
                    w_cnt_nxt   = 5'd0;
                end
            end
            S_STORE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = r_addr_r + w_cnt_ext;
                bus.mem_wdata = r_result[w_cur_lsb +: 8];
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_FIN;
                    w_cnt_nxt   = 5'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 5'd1;
                end
            end
            S_FIN: begin
                bus.op_done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_mem_ctrl.sv
// ============================================================================
//  Module   : tb_matrix_mem_ctrl
//  Brief    : Directed bench for matrix_mem_ctrl with byte memory and ULA models.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_mem_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    matrix_mem_ctrl_if #(.ADDR_W(8)) bus ();

    matrix_mem_ctrl #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory, one-cycle read latency
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we)    mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // ULA model: done is sampled high on the ula_w-th EXEC edge; opcode 3 adds bytewise
    int ula_w = 2;
    int ula_cnt;
    function automatic logic [199:0] add_bytes(input logic [199:0] a, input logic [199:0] b);
        logic [199:0] s;
        for (int k = 0; k < 25; k++) s[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bus.done              <= 1'b0;
            bus.matriz_resultante <= '0;
            ula_cnt               <= 0;
        end else if (bus.start) begin
            if (!bus.done) begin
                if (ula_cnt + 1 == ula_w - 1) begin
                    bus.done <= 1'b1;
                    if (bus.opcode == 4'd3)
                        bus.matriz_resultante <= add_bytes(bus.matrizA, bus.matrizB);
                end
                ula_cnt <= ula_cnt + 1;
            end
        end else begin
            bus.done <= 1'b0;
            ula_cnt  <= 0;
        end
    end

    logic [199:0] snap_a;
    logic [3:0]   snap_op;
    logic [7:0]   snap_sc;

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            mem[8'(a + 8'(k))] <= 8'(k);
            mem[8'(b + 8'(k))] <= 8'(2 * k);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] sc,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                           input bit hold, output int lat, output int acc);
        int   c;
        logic ps, pd;
        bit   snapped;
        lat = -1; acc = 0; ps = 0; pd = 0; snapped = 0;
        @(negedge clk);
        bus.cmd_opcode  = op;
        bus.cmd_escalar = sc;
        bus.cmd_addr_a  = a;
        bus.cmd_addr_b  = b;
        bus.cmd_addr_r  = r;
        bus.cmd_valid   = 1'b1;
        if (bus.cmd_ready) acc = 1;
        @(negedge clk);
        c = 1;
        if (!hold) bus.cmd_valid = 1'b0;
        while (c <= 300) begin
            checks++;
            if (bus.mem_rd_en && bus.mem_we) begin
                errors++;
                $display("FAIL strobe_excl cycle %0d: rd_en=1 and we=1 together", c);
            end
            if (hold && bus.cmd_valid && bus.cmd_ready) acc++;
            if (ps && !bus.start) begin
                checks++;
                if (!pd) begin
                    errors++;
                    $display("FAIL start_hold cycle %0d: start dropped while done was 0", c);
                end
            end
            if (bus.start && !snapped) begin
                snap_a  = bus.matrizA;
                snap_op = bus.opcode;
                snap_sc = bus.data_escalar;
                snapped = 1;
            end
            if (bus.op_done) begin
                lat = c;
                break;
            end
            ps = bus.start;
            pd = bus.done;
            @(negedge clk);
            c++;
        end
        bus.cmd_valid = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL op_done_timeout: no op_done within 300 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.start !== 1'b0 || bus.op_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b start=%b op_done=%b, need 1 0 0",
                     bus.cmd_ready, bus.start, bus.op_done);
        end
        checks++;
        if (bus.mem_rd_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem: rd=%b we=%b addr=%h wdata=%h, need 0 0 00 00",
                     bus.mem_rd_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.opcode !== 4'd0 || bus.data_escalar !== 8'd0 || bus.matrizA !== '0 || bus.matrizB !== '0) begin
            errors++;
            $display("FAIL reset_regs: opcode=%h escalar=%h matrices nonzero or X", bus.opcode, bus.data_escalar);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.mem_rd_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_strobe cycle %0d: rd=%b we=%b ready=%b, need 0 0 1",
                         i, bus.mem_rd_en, bus.mem_we, bus.cmd_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add();
        int lat, acc;
        load_ab(8'h00, 8'h20);
        ula_w = 2;
        run_cmd(4'd3, 8'h5A, 8'h00, 8'h20, 8'h40, 0, lat, acc);
        checks++;
        if (lat != 79) begin
            errors++;
            $display("FAIL add_latency: op_done at cycle %0d, need 79", lat);
        end
        checks++;
        if (snap_op !== 4'd3 || snap_sc !== 8'h5A) begin
            errors++;
            $display("FAIL add_fields: opcode=%h escalar=%h, need 3 5a", snap_op, snap_sc);
        end
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (mem[8'h40 + 8'(k)] !== 8'(3 * k)) begin
                errors++;
                $display("FAIL add_result[%0d]: got %h, need %h", k, mem[8'h40 + 8'(k)], 8'(3 * k));
            end
        end
    endtask

    task automatic test_packing();
        int lat, acc;
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            mem[8'h80 + 8'(k)] <= 8'h00;
            mem[8'hA0 + 8'(k)] <= 8'h00;
        end
        mem[8'h80] <= 8'hAA;
        mem[8'h98] <= 8'h55;
        run_cmd(4'd3, 8'h00, 8'h80, 8'hA0, 8'hC0, 0, lat, acc);
        checks++;
        if (snap_a[7:0] !== 8'hAA || snap_a[199:192] !== 8'h55 || snap_a[191:8] !== '0) begin
            errors++;
            $display("FAIL packing: A[0]=%h A[24]=%h mid_zero=%b, need aa 55 1",
                     snap_a[7:0], snap_a[199:192], snap_a[191:8] === '0);
        end
        checks++;
        if (mem[8'hC0] !== 8'hAA || mem[8'hD8] !== 8'h55) begin
            errors++;
            $display("FAIL packing_store: r[0]=%h r[24]=%h, need aa 55", mem[8'hC0], mem[8'hD8]);
        end
    endtask

    task automatic test_wrap();
        int lat, acc;
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            mem[8'hF0 + 8'(k)] <= 8'hFF;
            mem[8'h20 + 8'(k)] <= 8'h02;
        end
        run_cmd(4'd3, 8'h00, 8'hF0, 8'h20, 8'h40, 0, lat, acc);
        for (int k = 0; k < 25; k += 4) begin
            checks++;
            if (mem[8'h40 + 8'(k)] !== 8'h01) begin
                errors++;
                $display("FAIL wrap_result[%0d]: got %h, need 01", k, mem[8'h40 + 8'(k)]);
            end
        end
        checks++;
        if (mem[8'h58] !== 8'h01) begin
            errors++;
            $display("FAIL wrap_result[24]: got %h, need 01", mem[8'h58]);
        end
    endtask

    task automatic test_busy();
        int lat, acc;
        load_ab(8'h00, 8'h20);
        ula_w = 10;
        run_cmd(4'd3, 8'h00, 8'h00, 8'h20, 8'h90, 1, lat, acc);
        ula_w = 2;
        checks++;
        if (acc != 1) begin
            errors++;
            $display("FAIL busy_accepts: %0d commands accepted, need 1", acc);
        end
        checks++;
        if (lat != 87) begin
            errors++;
            $display("FAIL busy_latency: op_done at cycle %0d, need 87", lat);
        end
        checks++;
        if (mem[8'h90] !== 8'h00 || mem[8'hA8] !== 8'd72) begin
            errors++;
            $display("FAIL busy_result: r[0]=%h r[24]=%h, need 00 48", mem[8'h90], mem[8'hA8]);
        end
    endtask

    task automatic test_reset_mid_store();
        int  lat, acc;
        bit  hit;
        load_ab(8'h00, 8'h20);
        @(negedge clk);
        for (int k = 0; k < 25; k++) mem[8'h60 + 8'(k)] <= 8'hEE;
        bus.cmd_opcode = 4'd3;
        bus.cmd_escalar = 8'h00;
        bus.cmd_addr_a = 8'h00;
        bus.cmd_addr_b = 8'h20;
        bus.cmd_addr_r = 8'h60;
        bus.cmd_valid  = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.mem_we && bus.mem_addr == 8'h6C) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_store_reach: STORE k=12 never seen");
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.start !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: we=%b ready=%b start=%b, need 0 1 0",
                     bus.mem_we, bus.cmd_ready, bus.start);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.matrizA !== '0 || bus.opcode !== 4'd0) begin
            errors++;
            $display("FAIL rst_release: ready=%b opcode=%h, need 1 0 with matrizA 0",
                     bus.cmd_ready, bus.opcode);
        end
        checks++;
        if (mem[8'h6B] !== 8'd33 || mem[8'h6C] !== 8'hEE) begin
            errors++;
            $display("FAIL rst_partial: r[11]=%h r[12]=%h, need 21 ee", mem[8'h6B], mem[8'h6C]);
        end
        run_cmd(4'd3, 8'h00, 8'h00, 8'h20, 8'h60, 0, lat, acc);
        checks++;
        if (lat != 79) begin
            errors++;
            $display("FAIL rst_rerun_latency: op_done at cycle %0d, need 79", lat);
        end
        for (int k = 10; k < 25; k += 2) begin
            checks++;
            if (mem[8'h60 + 8'(k)] !== 8'(3 * k)) begin
                errors++;
                $display("FAIL rst_rerun[%0d]: got %h, need %h", k, mem[8'h60 + 8'(k)], 8'(3 * k));
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = 4'd0;
        bus.cmd_escalar = 8'd0;
        bus.cmd_addr_a  = 8'd0;
        bus.cmd_addr_b  = 8'd0;
        bus.cmd_addr_r  = 8'd0;
        test_reset();
        test_add();
        test_packing();
        test_wrap();
        test_busy();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
